data_mem_mmio: RTL and testbench



---
 rtl/mmio_pkg.sv | 21 ++
 rtl/data_mem_mmio_if.sv | 31 +++
 rtl/tx_fifo.sv | 66 ++++++
 rtl/data_mem_mmio.sv | 150 +++++++++++++++
 tb/tb_data_mem_mmio.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-stage data RAM / MMIO slave.
// Holds the MMIO page select value, the register offsets within the page
// and the bit layout of the TXSTAT status word.
package mmio_pkg;

   localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

   typedef enum logic [3:0] {
      OFF_LED    = 4'h0,
      OFF_CYCLE  = 4'h4,
      OFF_TXDATA = 4'h8,
      OFF_TXSTAT = 4'hC
   } mmio_off_e;

   localparam int TXSTAT_FULL_BIT  = 0;
   localparam int TXSTAT_EMPTY_BIT = 1;
   localparam int TXSTAT_OVF_BIT   = 2;
   localparam int TXSTAT_CNT_LSB   = 8;
   localparam int TXSTAT_CNT_W     = 8;

endpackage

// File: rtl/data_mem_mmio_if.sv
// M-stage memory bus between the core and the data memory / MMIO slave.
//   MemWriteM  store strobe
//   ByteM      byte (1) / word (0) access
//   ALUResult  byte address
//   WriteData  store data
//   ReadData   load data, combinational from the address
interface data_mem_mmio_if;

   logic        MemWriteM;
   logic        ByteM;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (
      output MemWriteM,
      output ByteM,
      output ALUResult,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  MemWriteM,
      input  ByteM,
      input  ALUResult,
      input  WriteData,
      output ReadData
   );

endinterface

// File: rtl/tx_fifo.sv
// Byte-wide circular TX FIFO.
//   clk, reset   clock, synchronous active-high reset
//   push         write push_data at the tail (dropped when full and no pop)
//   push_data    byte to enqueue
//   pop          remove the head entry (ignored when empty)
//   head         current head entry, don't-care when empty
//   count        number of stored entries
//   full, empty  status flags
module tx_fifo #(
   parameter  int FIFO_DEPTH = 4,
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    buf_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full  = (cnt_q == CW'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign head  = buf_q[rd_ptr_q];

   // A push into a full FIFO is still accepted when the head leaves in the
   // same cycle; the tail slot then coincides with the slot being freed.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         buf_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/data_mem_mmio.sv
// Memory-stage slave: word-organised data RAM plus a small MMIO page
// (LED register, free-running cycle counter, byte TX FIFO with valid/ready).
//   clk, reset   clock, synchronous active-high reset
//   bus          M-stage memory bus (slave side)
//   led          LED register contents
//   tx_data      TX FIFO head byte
//   tx_valid     TX FIFO non-empty
//   tx_ready     consumer takes the head this cycle
module data_mem_mmio
   import mmio_pkg::*;
#(
   parameter int          DEPTH        = 64,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] MMIO_BASE_HI = mmio_pkg::MMIO_BASE_HI,
   parameter string       INIT_FILE    = ""
) (
   input  logic                   clk,
   input  logic                   reset,
   data_mem_mmio_if.slave         bus,
   output logic [7:0]             led,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   mem [DEPTH];

   logic          is_mmio;
   logic [AW-1:0] ram_idx;
   logic [1:0]    lane;
   logic [3:0]    off;
   logic          ram_we;
   logic          mmio_we;

   logic [7:0]    led_q, led_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          ovf_q, ovf_d;

   logic          fifo_push;
   logic          fifo_pop;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   logic [31:0]   ram_word;
   logic [7:0]    ram_byte;
   logic [31:0]   txstat;

   // Address bits between the RAM index and the page select only matter
   // for the page offset / index, the rest are intentionally ignored.
   logic          unused_addr;
   assign unused_addr = ^bus.ALUResult[15:AW+2];

   assign is_mmio = (bus.ALUResult[31:16] == MMIO_BASE_HI);
   assign ram_idx = bus.ALUResult[AW+1:2];
   assign lane    = bus.ALUResult[1:0];
   assign off     = bus.ALUResult[3:0];
   assign ram_we  = bus.MemWriteM & ~is_mmio & ~reset;
   assign mmio_we = bus.MemWriteM & is_mmio;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         if (bus.ByteM) begin
            mem[ram_idx][{lane, 3'b000} +: 8] <= bus.WriteData[7:0];
         end else begin
            mem[ram_idx] <= bus.WriteData;
         end
      end
   end

   assign fifo_push = mmio_we && (off == OFF_TXDATA);
   assign fifo_pop  = tx_valid & tx_ready;

   tx_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (bus.WriteData[7:0]),
      .pop       (fifo_pop),
      .head      (tx_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign tx_valid = ~fifo_empty;
   assign led      = led_q;

   always_comb begin
      led_d = led_q;
      cyc_d = cyc_q + 32'd1;
      ovf_d = ovf_q;
      if (mmio_we && (off == OFF_LED)) begin
         led_d = bus.WriteData[7:0];
      end
      if (mmio_we && (off == OFF_TXSTAT)) begin
         ovf_d = 1'b0;
      end
      // A push and a TXSTAT write cannot coincide (single address per cycle).
      if (fifo_push && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= '0;
         cyc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         led_q <= led_d;
         cyc_q <= cyc_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      txstat                                     = '0;
      txstat[TXSTAT_CNT_LSB +: TXSTAT_CNT_W]     = TXSTAT_CNT_W'(fifo_count);
      txstat[TXSTAT_OVF_BIT]                     = ovf_q;
      txstat[TXSTAT_EMPTY_BIT]                   = fifo_empty;
      txstat[TXSTAT_FULL_BIT]                    = fifo_full;
   end

   assign ram_word = mem[ram_idx];
   assign ram_byte = ram_word[{lane, 3'b000} +: 8];

   // Reads see pre-edge contents; a same-cycle store lands at the clock edge.
   always_comb begin
      bus.ReadData = '0;
      if (is_mmio) begin
         case (off)
            OFF_LED:    bus.ReadData = {24'b0, led_q};
            OFF_CYCLE:  bus.ReadData = cyc_q;
            OFF_TXSTAT: bus.ReadData = txstat;
            default:    bus.ReadData = '0;
         endcase
      end else if (bus.ByteM) begin
         bus.ReadData = {24'b0, ram_byte};
      end else begin
         bus.ReadData = ram_word;
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

   logic       clk;
   logic       reset;
   logic [7:0] led;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   data_mem_mmio_if bus ();

   data_mem_mmio #(
      .DEPTH      (64),
      .FIFO_DEPTH (4),
      .INIT_FILE  ("")
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .led      (led),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb [$];
   logic [7:0]  fq [$];

   localparam logic [31:0] A_LED    = 32'hFFFF_0000;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
   localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
   localparam logic [31:0] A_TXSTAT = 32'hFFFF_000C;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic b);
      bus.MemWriteM = 1'b1;
      bus.ByteM     = b;
      bus.ALUResult = a;
      bus.WriteData = d;
      tick();
      bus.MemWriteM = 1'b0;
      bus.ByteM     = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic b, input logic [31:0] exp);
      logic [31:0] got;
      sb.push_back(exp);
      bus.ALUResult = a;
      bus.ByteM     = b;
      #1;
      got = bus.ReadData;
      check(tag, got, sb.pop_front());
      bus.ByteM = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] v, input logic expect_kept);
      if (expect_kept) fq.push_back(v);
      wr(A_TXDATA, {24'hABCDEF, v}, 1'b0);
   endtask

   task automatic drain_check(input string tag);
      check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      check({tag, "_data"}, {24'b0, tx_data}, {24'b0, fq.pop_front()});
      tick();
   endtask

   initial begin
      reset         = 1'b1;
      tx_ready      = 1'b0;
      bus.MemWriteM = 1'b0;
      bus.ByteM     = 1'b0;
      bus.ALUResult = '0;
      bus.WriteData = '0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_led", {24'b0, led}, 32'd0);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);

      // cycle counter: 10 edges since reset deasserted
      for (int i = 0; i < 10; i++) tick();
      rd("cycle_10", A_CYCLE, 1'b0, 32'd10);
      wr(A_CYCLE, 32'h0000_0000, 1'b0);
      rd("cycle_wr_ignored", A_CYCLE, 1'b0, 32'd11);
      rd("led_rst_read", A_LED, 1'b0, 32'd0);

      wr(A_LED, 32'h1234_565A, 1'b0);
      check("led_port", {24'b0, led}, 32'h5A);
      rd("led_read_bytem", A_LED, 1'b1, 32'h0000_005A);
      rd("mmio_unused_off", 32'hFFFF_0001, 1'b0, 32'd0);
      rd("txdata_read", A_TXDATA, 1'b0, 32'd0);
      rd("txstat_idle", A_TXSTAT, 1'b0, 32'h0000_0002);

      // RAM word, alias, byte lane
      wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      rd("ram_word", 32'h0000_0010, 1'b0, 32'hDEAD_BEEF);
      rd("ram_alias", 32'h0000_0110, 1'b0, 32'hDEAD_BEEF);
      wr(32'h0000_0010, 32'h1122_3344, 1'b0);
      wr(32'h0000_0013, 32'hFFFF_FFAB, 1'b1);
      rd("ram_byte_merge", 32'h0000_0010, 1'b0, 32'hAB22_3344);
      rd("ram_byte_rd3", 32'h0000_0013, 1'b1, 32'h0000_00AB);
      rd("ram_byte_rd0", 32'h0000_0010, 1'b1, 32'h0000_0044);
      rd("ram_byte_rd1", 32'h0000_0011, 1'b1, 32'h0000_0033);

      // read during write returns old data
      tick();
      bus.MemWriteM = 1'b1;
      bus.ALUResult = 32'h0000_0010;
      bus.WriteData = 32'hCAFE_F00D;
      #1;
      check("ram_rdw_old", bus.ReadData, 32'hAB22_3344);
      tick();
      bus.MemWriteM = 1'b0;
      rd("ram_rdw_new", 32'h0000_0010, 1'b0, 32'hCAFE_F00D);

      // FIFO fill with overflow, then drain
      tick();
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push_tx(8'(i), i <= 4);
      rd("txstat_full_ovf", A_TXSTAT, 1'b0, 32'h0000_0405);
      wr(A_TXSTAT, 32'h0, 1'b0);
      rd("txstat_ovf_clr", A_TXSTAT, 1'b0, 32'h0000_0401);
      tick();
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) drain_check("drain1");
      check("drain1_end_valid", {31'b0, tx_valid}, 32'd0);
      rd("txstat_empty", A_TXSTAT, 1'b0, 32'h0000_0002);

      // push into empty FIFO is not bypassed
      tick();
      bus.MemWriteM = 1'b1;
      bus.ALUResult = A_TXDATA;
      bus.WriteData = 32'h0000_0099;
      #1;
      check("nobypass_valid", {31'b0, tx_valid}, 32'd0);
      tick();
      bus.MemWriteM = 1'b0;
      fq.push_back(8'h99);
      drain_check("nobypass");
      check("nobypass_gone", {31'b0, tx_valid}, 32'd0);

      // full FIFO with simultaneous pop and push
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_tx(8'h11 + 8'(i), 1'b1);
      tx_ready = 1'b1;
      check("fullpp_head", {24'b0, tx_data}, {24'b0, fq.pop_front()});
      push_tx(8'h77, 1'b1);
      rd("fullpp_txstat", A_TXSTAT, 1'b0, 32'h0000_0401);
      for (int i = 0; i < 4; i++) drain_check("fullpp");
      check("fullpp_end_valid", {31'b0, tx_valid}, 32'd0);

      // reset mid-drain with a concurrent push
      tick();
      tx_ready = 1'b0;
      wr(A_LED, 32'h0000_003C, 1'b0);
      push_tx(8'h21, 1'b1);
      push_tx(8'h22, 1'b1);
      push_tx(8'h23, 1'b1);
      tx_ready = 1'b1;
      drain_check("middrain");
      check("middrain_head", {24'b0, tx_data}, {24'b0, fq.pop_front()});
      reset         = 1'b1;
      bus.MemWriteM = 1'b1;
      bus.ALUResult = A_TXDATA;
      bus.WriteData = 32'h0000_0044;
      tick();
      reset         = 1'b0;
      bus.MemWriteM = 1'b0;
      fq.delete();
      check("rst2_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst2_led", {24'b0, led}, 32'd0);
      rd("rst2_cycle", A_CYCLE, 1'b0, 32'd0);
      rd("rst2_txstat", A_TXSTAT, 1'b0, 32'h0000_0002);
      rd("rst2_ram_kept", 32'h0000_0010, 1'b0, 32'hCAFE_F00D);
      tx_ready = 1'b0;

      // store during reset is suppressed
      reset         = 1'b1;
      bus.MemWriteM = 1'b1;
      bus.ALUResult = 32'h0000_0010;
      bus.WriteData = 32'h5555_AAAA;
      tick();
      reset         = 1'b0;
      bus.MemWriteM = 1'b0;
      rd("rst_store_blocked", 32'h0000_0010, 1'b0, 32'hCAFE_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
